// File: rtl/pp_row_accumulator_pkg.sv
// Shared definitions for the approximate 16x16 multiplier's row accumulation stage:
// geometry, FSM state encoding and the row-packing helper.
package pp_row_accumulator_pkg;

   localparam int PP_ROWS = 8;
   localparam int PP_W    = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } acc_state_t;

   typedef logic [PP_ROWS-1:0][PP_W-1:0] row_set_t;

   // Row i lands at bit offset i*PP_W of the flat bus.
   function automatic logic [PP_ROWS*PP_W-1:0] pack_rows(input row_set_t rows);
      logic [PP_ROWS*PP_W-1:0] flat_s;
      flat_s = '0;
      for (int i = 0; i < PP_ROWS; i++) begin
         flat_s[i*PP_W +: PP_W] = rows[i];
      end
      return flat_s;
   endfunction

endpackage

// File: rtl/pp_row_accumulator_csa.sv
// W-bit 3:2 carry-save row compressor; the carry vector comes out already shifted
// one column left, and the carry from the top column is dropped.
module csa_row_3to2 #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);

   logic [W-1:0] maj_s;

   // Bitwise full-adder sum and majority.
   always_comb begin
      maj_s = (a & b) | (a & c) | (b & c);
      sum   = a ^ b ^ c;
      carry = {maj_s[W-2:0], 1'b0};
   end

endmodule

// File: rtl/pp_row_accumulator.sv
// Sequential accumulator: absorbs one partial-product row per cycle into a carry-save
// pair, then resolves it with a single carry-propagate add.
module pp_row_accumulator
   import pp_row_accumulator_pkg::*;
#(
   parameter int ROWS = PP_ROWS,
   parameter int W    = PP_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ROWS*W-1:0] in_rows,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    out_data,
   output logic            busy
);

   localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   acc_state_t        state_r;
   acc_state_t        state_s;
   logic [IDX_W-1:0]  idx_r;
   logic [ROWS*W-1:0] row_buf_r;
   logic [W-1:0]      sum_r;
   logic [W-1:0]      carry_r;
   logic [W-1:0]      row_sel_s;
   logic [W-1:0]      csa_sum_s;
   logic [W-1:0]      csa_carry_s;
   logic              accept_s;
   logic              in_ready_r;
   logic              out_valid_r;
   logic              busy_r;
   logic [W-1:0]      out_data_r;

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign out_data  = out_data_r;

   assign accept_s  = in_valid & in_ready_r;
   assign row_sel_s = row_buf_r[idx_r*W +: W];

   csa_row_3to2 #(.W(W)) u_csa (
      .a     (sum_r),
      .b     (carry_r),
      .c     (row_sel_s),
      .sum   (csa_sum_s),
      .carry (csa_carry_s)
   );

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_s = ST_ACCUM;
            else          state_s = ST_IDLE;
         end
         ST_ACCUM: begin
            if (idx_r == IDX_W'(ROWS - 1)) state_s = ST_FINAL;
            else                           state_s = ST_ACCUM;
         end
         ST_FINAL: state_s = ST_DONE;
         ST_DONE: begin
            if (out_ready) state_s = ST_IDLE;
            else           state_s = ST_DONE;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register and handshake/status flags, decoded from the next state so
   // they are registered yet change on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         in_ready_r  <= (state_s == ST_IDLE);
         out_valid_r <= (state_s == ST_DONE);
         busy_r      <= (state_s == ST_ACCUM) || (state_s == ST_FINAL);
      end
   end

   // Row buffer, carry-save pair, row index and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_buf_r  <= '0;
         sum_r      <= '0;
         carry_r    <= '0;
         idx_r      <= '0;
         out_data_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  row_buf_r <= in_rows;
                  sum_r     <= '0;
                  carry_r   <= '0;
                  idx_r     <= '0;
               end
            end
            ST_ACCUM: begin
               sum_r   <= csa_sum_s;
               carry_r <= csa_carry_s;
               idx_r   <= idx_r + IDX_W'(1);
            end
            ST_FINAL: out_data_r <= sum_r + carry_r;
            ST_DONE:  out_data_r <= out_data_r;
            default:  idx_r      <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_pp_row_accumulator.sv
// Scoreboard bench for pp_row_accumulator: directed row sets with hand-computed sums,
// checked by a monitor that pops expectations on every output transfer.
module tb_pp_row_accumulator;
   import pp_row_accumulator_pkg::*;

   logic                    clk;
   logic                    rst_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [PP_ROWS*PP_W-1:0] in_rows;
   logic                    out_valid;
   logic                    out_ready;
   logic [PP_W-1:0]         out_data;
   logic                    busy;

   int n_cmp;
   int n_err;
   logic [PP_W-1:0] exp_q[$];

   pp_row_accumulator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rows   (in_rows),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
      end
   endtask

   // Output side of the scoreboard: one pop per completed output transfer.
   task automatic monitor();
      logic [31:0] want;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_output: got 0x%08h, expected no transfer", out_data);
            end else begin
               want = exp_q.pop_front();
               check("out_data", out_data, want);
            end
         end
      end
   endtask

   task automatic send(input logic [PP_ROWS*PP_W-1:0] rows, input logic [31:0] want,
                       input bit push);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
      end else begin
         in_rows  = rows;
         in_valid = 1'b1;
         @(posedge clk);
         if (push) exp_q.push_back(want);
         #1;
         in_valid = 1'b0;
         in_rows  = {PP_ROWS*PP_W{1'b1}};
      end
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || out_valid) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("drain_timeout", 32'd0, 32'd1);
   endtask

   function automatic logic [PP_ROWS*PP_W-1:0] const_rows(input logic [31:0] v);
      row_set_t r;
      for (int i = 0; i < PP_ROWS; i++) r[i] = v;
      return pack_rows(r);
   endfunction

   function automatic logic [PP_ROWS*PP_W-1:0] ramp_rows(input logic [31:0] step);
      row_set_t r;
      for (int i = 0; i < PP_ROWS; i++) r[i] = step * 32'(i + 1);
      return pack_rows(r);
   endfunction

   // Radix-4 style partial products: row i covers multiplier bits 2i and 2i+1.
   function automatic logic [PP_ROWS*PP_W-1:0] mult_rows(input logic [15:0] a,
                                                          input logic [15:0] b);
      row_set_t r;
      for (int i = 0; i < PP_ROWS; i++) begin
         r[i] = (32'(a) * 32'(b[2*i +: 2])) << (2 * i);
      end
      return pack_rows(r);
   endfunction

   initial begin
      int n;
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_rows   = '0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_data", out_data, 32'h0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      fork
         monitor();
      join_none

      // All-zero rows, with latency measurement.
      send(const_rows(32'h0), 32'h0000_0000, 1'b1);
      check("accum_busy", 32'(busy), 32'd1);
      check("accum_in_ready", 32'(in_ready), 32'd0);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", 32'(n), 32'd9);
      wait_idle();

      send(ramp_rows(32'd1), 32'h0000_0024, 1'b1);
      send(const_rows(32'hFFFF_FFFF), 32'hFFFF_FFF8, 1'b1);
      send(mult_rows(16'hFFFF, 16'hFFFF), 32'hFFFE_0001, 1'b1);
      send(mult_rows(16'h1234, 16'h5678), 32'h0626_0060, 1'b1);
      send(ramp_rows(32'h1111_1111), 32'h6666_6664, 1'b1);
      wait_idle();

      // Back-pressure: result held, input ignored.
      @(negedge clk);
      out_ready = 1'b0;
      send(ramp_rows(32'h1111_1111), 32'h6666_6664, 1'b1);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("hold_reached_done", 32'(out_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_rows  = const_rows(32'h0000_0001);
         in_valid = 1'b1;
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_out_data", out_data, 32'h6666_6664);
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release_in_ready", 32'(in_ready), 32'd1);
      check("release_out_valid", 32'(out_valid), 32'd0);
      repeat (12) @(negedge clk);
      wait_idle();

      // Abort mid-accumulation.
      send(ramp_rows(32'd1), 32'h0000_0024, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("abort_recover_in_ready", 32'(in_ready), 32'd1);
      send(ramp_rows(32'd1), 32'h0000_0024, 1'b1);
      wait_idle();
      repeat (12) @(negedge clk);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
